// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_fifo_pkg
// Brief  : Shared receiver constants and FSM state encoding.
// Rev    : 1.0
// ============================================================================
package uart_rx_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_START  = 7;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_fifo
// Brief  : First-word-fall-through FIFO with registered occupancy count.
// Rev    : 1.0
// ============================================================================
module uart_fifo #(
    parameter int DBIT   = 8,
    parameter int FIFO_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic            rd,
    input  logic [DBIT-1:0] w_data,
    output logic [DBIT-1:0] r_data,
    output logic            empty,
    output logic            full
);

    localparam int DEPTH = 1 << FIFO_W;
    localparam logic [FIFO_W:0] c_DEPTH = (FIFO_W+1)'(DEPTH);

    logic [DBIT-1:0]   r_mem [DEPTH];
    logic [FIFO_W-1:0] r_wr_ptr;
    logic [FIFO_W-1:0] r_rd_ptr;
    logic [FIFO_W:0]   r_count;
    logic              w_pop;
    logic              w_push_ok;

    // A pop frees a slot in the same cycle, so a write to a full FIFO is legal then.
    assign w_pop     = rd & ~empty;
    assign w_push_ok = wr & (~full | w_pop);
    assign empty     = (r_count == '0);
    assign full      = (r_count == c_DEPTH);
    assign r_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_fifo
// Brief  : 16x-oversampled UART receiver feeding a FWFT byte FIFO.
// Rev    : 1.0
// ============================================================================
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    input  logic            rd_uart,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            frame_err,
    output logic            overrun
);

    // The tick counter only widens when the stop period exceeds one bit time.
    localparam int TICK_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
    localparam int BIT_W  = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TICK_W-1:0] c_MID_TICK  = TICK_W'(MID_START);
    localparam logic [TICK_W-1:0] c_LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] c_STOP_TICK = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  c_LAST_BIT  = BIT_W'(DBIT - 1);

    rx_state_t         r_state;
    logic [1:0]        r_sync;
    logic [TICK_W-1:0] r_tick;
    logic [BIT_W-1:0]  r_bit;
    logic [DBIT-1:0]   r_shift;
    logic              r_frame_err;
    logic              r_overrun;
    logic              w_rxs;
    logic              w_stop_done;
    logic              w_push;
    logic              w_pop;

    assign w_rxs       = r_sync[1];
    assign w_stop_done = (r_state == STOP) && s_tick && (r_tick == c_STOP_TICK);
    assign w_push      = w_stop_done & w_rxs;
    assign w_pop       = rd_uart & ~rx_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                        r_tick  <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (r_tick == c_MID_TICK) begin
                            r_state <= w_rxs ? IDLE : DATA;
                            r_tick  <= '0;
                            r_bit   <= '0;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (r_tick == c_LAST_TICK) begin
                            r_tick  <= '0;
                            r_shift <= {w_rxs, r_shift[DBIT-1:1]};
                            if (r_bit == c_LAST_BIT) begin
                                r_state <= STOP;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (r_tick == c_STOP_TICK) begin
                            r_state     <= IDLE;
                            r_tick      <= '0;
                            r_frame_err <= ~w_rxs;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Dropped byte: a completed frame finds the FIFO full with no pop to make room.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push & rx_full & ~w_pop;
        end
    end

    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

    uart_fifo #(
        .DBIT   (DBIT),
        .FIFO_W (FIFO_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (w_push),
        .rd     (rd_uart),
        .w_data (r_shift),
        .r_data (r_data),
        .empty  (rx_empty),
        .full   (rx_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_fifo
// Brief  : Directed self-checking bench for the UART receive FIFO.
// Rev    : 1.0
// ============================================================================
module tb_uart_rx_fifo;

    localparam int BIT_CLKS = 256;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       s_tick = 1'b0;
    logic       rd_uart;
    logic [7:0] r_data;
    logic       rx_empty;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;

    logic [3:0] tick_div = 4'd0;
    int         total = 0;
    int         bad   = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;

    uart_rx_fifo #(
        .DBIT    (8),
        .SB_TICK (16),
        .FIFO_W  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .s_tick    (s_tick),
        .rd_uart   (rd_uart),
        .r_data    (r_data),
        .rx_empty  (rx_empty),
        .rx_full   (rx_full),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        s_tick   = (tick_div == 4'd15);
        tick_div = tick_div + 4'd1;
    end

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic good_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (good_stop) begin
            rx = 1'b1;
            repeat (BIT_CLKS) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (192) @(negedge clk);
            rx = 1'b1;
            repeat (64) @(negedge clk);
        end
        repeat (16) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk);
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        rx      = 1'b1;
        rd_uart = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_empty", rx_empty, 1);
        check("rst_full", rx_full, 0);
        check("rst_data", r_data, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        // single byte
        send_byte(8'hA5, 1'b1);
        check("a5_empty", rx_empty, 0);
        check("a5_data", r_data, 8'hA5);
        pop();
        check("a5_pop_empty", rx_empty, 1);

        // back-to-back bytes
        send_byte(8'h3C, 1'b1);
        send_byte(8'h81, 1'b1);
        send_byte(8'hFF, 1'b1);
        check("b2b_full", rx_full, 0);
        check("b2b_d0", r_data, 8'h3C);
        pop();
        check("b2b_d1", r_data, 8'h81);
        pop();
        check("b2b_d2", r_data, 8'hFF);
        pop();
        check("b2b_empty", rx_empty, 1);
        pop();
        check("pop_on_empty", rx_empty, 1);

        // fill and overrun
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i), 1'b1);
        end
        check("fill_full", rx_full, 1);
        check("fill_head", r_data, 8'h01);
        ov_cnt = 0;
        send_byte(8'h05, 1'b1);
        check("ovr_pulses", ov_cnt, 1);
        check("ovr_full", rx_full, 1);
        check("ovr_head", r_data, 8'h01);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_pop_data", r_data, 8'(i));
            pop();
        end
        check("ovr_drained", rx_empty, 1);
        check("ovr_notfull", rx_full, 0);

        // framing error
        fe_cnt = 0;
        send_byte(8'h55, 1'b0);
        check("ferr_pulses", fe_cnt, 1);
        check("ferr_empty", rx_empty, 1);
        repeat (10 * BIT_CLKS) @(negedge clk);
        check("ferr_idle_empty", rx_empty, 1);

        // start-bit glitch
        rx = 1'b0;
        repeat (64) @(negedge clk);
        rx = 1'b1;
        repeat (10 * BIT_CLKS) @(negedge clk);
        check("glitch_empty", rx_empty, 1);
        check("glitch_ferr", fe_cnt, 1);
        send_byte(8'h12, 1'b1);
        check("after_glitch_data", r_data, 8'h12);
        check("after_glitch_empty", rx_empty, 0);

        // reset in the middle of DATA bit 3 of 0x77, with 0x12 still queued
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = 1'b0;
        repeat (100) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_empty", rx_empty, 1);
        check("midrst_full", rx_full, 0);
        check("midrst_data", r_data, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_ovr", overrun, 0);
        repeat (5) @(negedge clk);
        rx    = 1'b1;
        reset = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        check("postrst_idle_empty", rx_empty, 1);
        send_byte(8'h9C, 1'b1);
        check("postrst_data", r_data, 8'h9C);
        check("postrst_empty", rx_empty, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
